exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer.sv | 171 +++++++++++++++++
 tb/tb_exec_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Command-driven ALU that reports each result to a UART transmitter as a byte frame.
// The frame is an optional sync byte, then the result bytes in LSB-first order.
module exec_sequencer #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          HEADER_EN = 1'b1,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_W-1:0]     cmd_a,
  input  logic [DATA_W-1:0]     cmd_b,
  input  logic [2:0]            cmd_op,
  output logic [2*DATA_W-1:0]   result,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  input  logic                  tx_busy,
  output logic                  done,
  output logic [15:0]           frame_count
);

  localparam int unsigned ResW     = 2 * DATA_W;
  localparam int unsigned NBytes   = (ResW + 7) / 8;
  localparam int unsigned ExtW     = NBytes * 8;
  localparam int unsigned FrameLen = NBytes + (HEADER_EN ? 1 : 0);

  localparam logic [2:0]        LastIdx = 3'(FrameLen - 1);
  localparam logic [2:0]        HdrOff  = HEADER_EN ? 3'd1 : 3'd0;
  localparam logic [DATA_W-1:0] WMod    = DATA_W'(DATA_W);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StSend = 2'd2;
  localparam logic [1:0] StWait = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [ResW-1:0]   result_q, result_d;
  logic [2:0]        idx_q, idx_d;
  logic              busy_seen_q, busy_seen_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              done_q, done_d;
  logic [15:0]       frame_count_q, frame_count_d;

  logic [ResW-1:0]   a_ext, b_ext, alu_res;
  logic [DATA_W-1:0] shamt;
  logic [ExtW-1:0]   res_ext;
  logic [2:0]        data_idx;
  logic [7:0]        frame_byte;

  // Operands are zero-extended first so every opcode yields a full 2*DATA_W result.
  always_comb begin
    a_ext = {{DATA_W{1'b0}}, a_q};
    b_ext = {{DATA_W{1'b0}}, b_q};
    shamt = b_q % WMod;
    unique case (op_q)
      3'd0:    alu_res = a_ext + b_ext;
      3'd1:    alu_res = a_ext - b_ext;
      3'd2:    alu_res = a_ext * b_ext;
      3'd3:    alu_res = a_ext & b_ext;
      3'd4:    alu_res = a_ext | b_ext;
      3'd5:    alu_res = a_ext ^ b_ext;
      3'd6:    alu_res = a_ext << shamt;
      3'd7:    alu_res = a_ext >> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    res_ext    = ExtW'(result_q);
    data_idx   = idx_q - HdrOff;
    frame_byte = 8'h00;
    for (int unsigned i = 0; i < NBytes; i++) begin
      if (data_idx == 3'(i)) frame_byte = res_ext[i*8 +: 8];
    end
    if (HEADER_EN && idx_q == 3'd0) frame_byte = SYNC_BYTE;
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    result_d      = result_q;
    idx_d         = idx_q;
    busy_seen_d   = busy_seen_q;
    tx_start_d    = 1'b0;
    tx_byte_d     = tx_byte_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = alu_res;
        idx_d    = 3'd0;
        state_d  = StSend;
      end
      StSend: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = frame_byte;
          state_d    = StWait;
        end
      end
      StWait: begin
        // A byte counts as sent only after the transmitter has been seen busy and then idle.
        if (tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          busy_seen_d = 1'b0;
          idx_d       = idx_q + 3'd1;
          if (idx_q == LastIdx) begin
            state_d       = StIdle;
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      result_q      <= '0;
      idx_q         <= '0;
      busy_seen_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_byte_q     <= '0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      result_q      <= result_d;
      idx_q         <= idx_d;
      busy_seen_q   <= busy_seen_d;
      tx_start_q    <= tx_start_d;
      tx_byte_q     <= tx_byte_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign result      = result_q;
  assign tx_start    = tx_start_q;
  assign tx_byte     = tx_byte_q;
  assign done        = done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench: an 8-bit framed instance and a 12-bit headerless instance,
// each driving a simple UART busy model that records every byte sent.
module tb_exec_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        cmd_valid0, cmd_ready0, tx_start0, tx_busy0, done0;
  logic [7:0]  cmd_a0, cmd_b0, tx_byte0;
  logic [2:0]  cmd_op0;
  logic [15:0] result0, fc0;

  logic        cmd_valid1, cmd_ready1, tx_start1, tx_busy1, done1;
  logic [11:0] cmd_a1, cmd_b1;
  logic [7:0]  tx_byte1;
  logic [2:0]  cmd_op1;
  logic [23:0] result1;
  logic [15:0] fc1;

  exec_sequencer #(.DATA_W(8), .HEADER_EN(1'b1), .SYNC_BYTE(8'hA5)) u_dut0 (
    .clock(clk), .reset(rst_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_a(cmd_a0), .cmd_b(cmd_b0), .cmd_op(cmd_op0), .result(result0),
    .tx_start(tx_start0), .tx_byte(tx_byte0), .tx_busy(tx_busy0), .done(done0),
    .frame_count(fc0)
  );

  exec_sequencer #(.DATA_W(12), .HEADER_EN(1'b0), .SYNC_BYTE(8'hA5)) u_dut1 (
    .clock(clk), .reset(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_op(cmd_op1), .result(result1),
    .tx_start(tx_start1), .tx_byte(tx_byte1), .tx_busy(tx_busy1), .done(done1),
    .frame_count(fc1)
  );

  // UART model: busy for busy_len cycles after each start, optionally forced busy.
  int   busy_len = 3;
  logic ext_busy0 = 1'b0;
  int   busy_cnt0 = 0, busy_cnt1 = 0;
  logic [7:0] cap0 [64];
  logic [7:0] cap1 [64];
  int   ncap0 = 0, ncap1 = 0, viol0 = 0;

  assign tx_busy0 = (busy_cnt0 != 0) || ext_busy0;
  assign tx_busy1 = (busy_cnt1 != 0);

  always @(posedge clk) begin
    if (tx_start0) begin
      busy_cnt0         <= busy_len;
      cap0[ncap0 % 64]  <= tx_byte0;
      ncap0             <= ncap0 + 1;
      if (tx_busy0) viol0 <= viol0 + 1;
    end else if (busy_cnt0 > 0) begin
      busy_cnt0 <= busy_cnt0 - 1;
    end
    if (tx_start1) begin
      busy_cnt1         <= busy_len;
      cap1[ncap1 % 64]  <= tx_byte1;
      ncap1             <= ncap1 + 1;
    end else if (busy_cnt1 > 0) begin
      busy_cnt1 <= busy_cnt1 - 1;
    end
  end

  int n_checks = 0, n_fail = 0;
  int exp_fc0 = 0, exp_fc1 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one command to completion and checks result, frame bytes and status.
  task automatic run_frame(input int d, input logic [2:0] op, input logic [11:0] a,
                           input logic [11:0] b, input logic [23:0] exp_res,
                           input int exp_n, input logic [39:0] exp_bytes,
                           input bit inject, input int hold);
    int   base;
    bit   got_done;
    logic [7:0] got_b;
    for (int k = 0; k < 100 && !(d != 0 ? cmd_ready1 : cmd_ready0); k++) @(negedge clk);
    check_eq("ready_before_cmd", d != 0 ? cmd_ready1 : cmd_ready0, 1);
    base = (d != 0) ? ncap1 : ncap0;
    if (d != 0) begin
      cmd_valid1 = 1'b1; cmd_op1 = op; cmd_a1 = a; cmd_b1 = b;
    end else begin
      cmd_valid0 = 1'b1; cmd_op0 = op; cmd_a0 = a[7:0]; cmd_b0 = b[7:0];
    end
    @(negedge clk);
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
    got_done = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (inject && k == 5) begin
        check_eq("ready_midframe", cmd_ready0, 0);
        cmd_valid0 = 1'b1; cmd_op0 = 3'd4; cmd_a0 = 8'h00; cmd_b0 = 8'h00;
      end
      if (inject && k == 8) cmd_valid0 = 1'b0;
      if (hold > 0 && k == hold) begin
        check_eq("no_start_while_busy", ncap0 - base, 0);
        ext_busy0 = 1'b0;
      end
      if (d != 0 ? done1 : done0) begin
        got_done = 1'b1;
        break;
      end
    end
    check_eq("done_seen", got_done, 1);
    if (d != 0) exp_fc1++; else exp_fc0++;
    check_eq("ready_at_done", d != 0 ? cmd_ready1 : cmd_ready0, 1);
    check_eq("result", d != 0 ? result1 : {8'h00, result0}, exp_res);
    check_eq("frame_count", d != 0 ? fc1 : fc0, d != 0 ? exp_fc1 : exp_fc0);
    check_eq("byte_count", (d != 0 ? ncap1 : ncap0) - base, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      got_b = (d != 0) ? cap1[(base + i) % 64] : cap0[(base + i) % 64];
      check_eq("frame_byte", got_b, exp_bytes[i*8 +: 8]);
    end
    check_eq("tx_byte_hold", d != 0 ? tx_byte1 : tx_byte0, exp_bytes[(exp_n-1)*8 +: 8]);
    @(negedge clk);
    check_eq("done_one_cycle", d != 0 ? done1 : done0, 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    cmd_valid0 = 1'b0; cmd_a0 = '0; cmd_b0 = '0; cmd_op0 = '0;
    cmd_valid1 = 1'b0; cmd_a1 = '0; cmd_b1 = '0; cmd_op1 = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", cmd_ready0, 1);
    check_eq("rst_result", result0, 0);
    check_eq("rst_tx_start", tx_start0, 0);
    check_eq("rst_tx_byte", tx_byte0, 0);
    check_eq("rst_done", done0, 0);
    check_eq("rst_frame_count", fc0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    busy_len = 3;
    run_frame(0, 3'd0, 12'h005, 12'h00A, 24'h000F, 3, {8'h00, 8'h0F, 8'hA5}, 1'b0, 0);
    run_frame(0, 3'd2, 12'h0FF, 12'h0FF, 24'hFE01, 3, {8'hFE, 8'h01, 8'hA5}, 1'b0, 0);
    run_frame(0, 3'd1, 12'h003, 12'h005, 24'hFFFE, 3, {8'hFF, 8'hFE, 8'hA5}, 1'b0, 0);
    run_frame(0, 3'd6, 12'h081, 12'h009, 24'h0102, 3, {8'h01, 8'h02, 8'hA5}, 1'b0, 0);
    run_frame(0, 3'd7, 12'h080, 12'h00F, 24'h0001, 3, {8'h00, 8'h01, 8'hA5}, 1'b0, 0);
    run_frame(0, 3'd3, 12'h0F0, 12'h03C, 24'h0030, 3, {8'h00, 8'h30, 8'hA5}, 1'b0, 0);
    run_frame(0, 3'd4, 12'h0F0, 12'h00F, 24'h00FF, 3, {8'h00, 8'hFF, 8'hA5}, 1'b0, 0);
    run_frame(0, 3'd0, 12'h0FF, 12'h001, 24'h0100, 3, {8'h01, 8'h00, 8'hA5}, 1'b0, 0);

    // Slow transmitter plus a command offered mid-frame that must be ignored.
    busy_len = 20;
    run_frame(0, 3'd2, 12'h012, 12'h034, 24'h03A8, 3, {8'h03, 8'hA8, 8'hA5}, 1'b1, 0);

    // Transmitter already busy when the frame starts.
    busy_len = 3;
    ext_busy0 = 1'b1;
    run_frame(0, 3'd5, 12'h0FF, 12'h00F, 24'h00F0, 3, {8'h00, 8'hF0, 8'hA5}, 1'b0, 10);
    check_eq("start_while_busy", viol0, 0);

    run_frame(1, 3'd2, 12'hFFF, 12'hFFF, 24'hFFE001, 3, {8'hFF, 8'hE0, 8'h01}, 1'b0, 0);
    run_frame(1, 3'd6, 12'h801, 12'h00D, 24'h001002, 3, {8'h00, 8'h10, 8'h02}, 1'b0, 0);

    // Reset in the middle of a frame.
    busy_len = 20;
    base = ncap0;
    cmd_valid0 = 1'b1; cmd_op0 = 3'd0; cmd_a0 = 8'h05; cmd_b0 = 8'h0A;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    for (int k = 0; k < 500 && (ncap0 - base) < 2; k++) @(negedge clk);
    check_eq("two_bytes_before_reset", ncap0 - base, 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ready", cmd_ready0, 1);
    check_eq("arst_result", result0, 0);
    check_eq("arst_tx_start", tx_start0, 0);
    check_eq("arst_tx_byte", tx_byte0, 0);
    check_eq("arst_done", done0, 0);
    check_eq("arst_frame_count", fc0, 0);
    repeat (30) @(negedge clk);
    check_eq("no_bytes_in_reset", ncap0 - base, 2);
    rst_n = 1'b1;
    exp_fc0 = 0;
    exp_fc1 = 0;
    @(negedge clk);
    run_frame(0, 3'd0, 12'h005, 12'h00A, 24'h000F, 3, {8'h00, 8'h0F, 8'hA5}, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
